vshift_seq: RTL
===============

VSHIFT_SEQ -- requirements
Module: vshift_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, lane datapath width in bits (multiple of 64).
REQ-002 SHALL have parameter VL_W, default 8, width of the vector-length field.
REQ-003 SHALL have ports clk in 1 (single clock) and rst_n in 1 (reset, asynchronous, active-low).
REQ-004 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_op in 2 (00 srl, 01 sll, 10 sra, 11 reserved), cmd_sew in 3, cmd_vl in VL_W (element count).
REQ-005 SHALL have opnd_valid in 1, opnd_ready out 1, opnd_a in DATA_WIDTH (per-element shift amounts), opnd_b in DATA_WIDTH (data).
REQ-006 SHALL have res_valid out 1, res_ready in 1, res_data out DATA_WIDTH, res_last out 1.
REQ-007 SHALL have busy out 1, done out 1 (one-cycle pulse), err out 1 (valid with done).

Function
REQ-008 SHALL use states IDLE, RUN, DRAIN; cmd_ready=1 only in IDLE.
REQ-009 SHALL latch op, sew, vl on cmd_valid&&cmd_ready; chunk count = ceil(vl / (DATA_WIDTH/8 >> sew)).
REQ-010 SHALL, for sew>3, op=11 or vl=0, issue no chunks, go IDLE->DRAIN, pulse done next cycle; err=1 for sew>3 or op=11, err=0 for vl=0.
REQ-011 SHALL drive opnd_ready = (state==RUN) && (!res_valid || res_ready); a chunk transfers on opnd_valid&&opnd_ready.
REQ-012 SHALL compute each element as opnd_b element shifted by the low log2(SEW) bits of the same-position opnd_a element: srl logical right, sll left, sra arithmetic right.
REQ-013 SHALL register the result into a single output stage: latency 1 cycle from operand transfer to res_valid.
REQ-014 SHALL hold res_data/res_last stable while res_valid&&!res_ready; no chunk lost or duplicated under backpressure.
REQ-015 SHALL force elements with index >= vl in the final chunk to zero; res_last=1 on the final chunk only.
REQ-016 SHALL move RUN->DRAIN when the final chunk transfers; DRAIN->IDLE when res_valid&&res_ready&&res_last (or immediately per REQ-010), pulsing done in that cycle.
REQ-017 SHALL drive busy=1 whenever state!=IDLE.
REQ-018 SHALL handle simultaneous output drain and new operand transfer in one cycle at full throughput (one chunk/cycle).

Reset
REQ-019 SHALL, on rst_n low at any time including mid-operation, enter IDLE, clear chunk counter and latched command, drive cmd_ready=1, opnd_ready=0, res_valid=0, res_data=0, res_last=0, busy=0, done=0, err=0.
REQ-020 SHALL discard any in-flight chunk on reset with no done pulse.

Configuration
REQ-021 SHALL, with VSHIFT_SCALAR_EN defined, add ports cmd_scalar in 1 and cmd_scalar_amt in 6; when cmd_scalar=1 the latched cmd_scalar_amt replaces every element shift amount and opnd_a is ignored.
REQ-022 SHALL, without VSHIFT_SCALAR_EN, omit those ports and always use opnd_a.

Structure
REQ-023 SHALL place op encodings, sew encodings and the state enum in shared package vshift_pkg.
REQ-024 SHALL instantiate one combinational sub-module vshift_unit (operand_1, operand_2, sew, op -> result) for the element shifts.

Verification
REQ-025 SHALL cover: srl sew=0 vl=8, b=0x8080808080808080, a=0x0101010101010101 -> one chunk 0x4040404040404040, res_last=1, done.
REQ-026 SHALL cover: sll sew=1 vl=5, b=all 0x0001, a=all 0x0004 -> chunk0 0x0010001000100010, chunk1 0x0000000000000010 with res_last=1.
REQ-027 SHALL cover: sra sew=2 vl=2, b=0x80000000_00000010, a=0x00000004_00000004 -> 0xF8000000_00000001.
REQ-028 SHALL cover: res_ready held low 5 cycles mid-stream of a 4-chunk command -> opnd_ready low, res_data stable, all 4 chunks delivered in order.
REQ-029 SHALL cover: vl=0 -> done one cycle after accept, err=0, no res_valid; sew=4 -> done, err=1.
REQ-030 SHALL cover: rst_n asserted in RUN after chunk 1 of 3 -> all outputs at reset values, next command runs cleanly.

Source files
------------

// File: rtl/vshift_pkg.sv
// vshift_pkg: shared encodings for the vector shift sequencer
// (operation codes, element-width codes, sequencer states).
package vshift_pkg;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  // Element width is 8 << sew bits; codes above SEW_64 are illegal.
  typedef enum logic [2:0] {
    SEW_8  = 3'd0,
    SEW_16 = 3'd1,
    SEW_32 = 3'd2,
    SEW_64 = 3'd3
  } sew_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // A command that must complete with err set and no chunks issued.
  function automatic logic cmd_is_illegal(input logic [1:0] op, input logic [2:0] sew);
    return (sew > SEW_64) || (op == OP_RSV);
  endfunction

endpackage

// File: rtl/vshift_unit.sv
// vshift_unit: combinational per-element shifter. Every element width is
// computed in parallel and the one matching sew is selected. Each element
// shifts by the low log2(SEW) bits of the same-position amount element.
module vshift_unit
  import vshift_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] operand_1,  // per-element shift amounts
  input  logic [DATA_WIDTH-1:0] operand_2,  // element data
  input  logic [1:0]            sew,
  input  logic [1:0]            op,
  output logic [DATA_WIDTH-1:0] result
);

  logic [3:0][DATA_WIDTH-1:0] res_by_sew;

  for (genvar s = 0; s < 4; s++) begin : g_sew
    localparam int W  = 8 << s;
    localparam int SH = 3 + s;
    for (genvar i = 0; i < DATA_WIDTH / W; i++) begin : g_elem
      logic        [SH-1:0] amt;
      logic        [W-1:0]  data;
      logic        [W-1:0]  srl_res;
      logic        [W-1:0]  sll_res;
      logic signed [W-1:0]  sdata;
      logic signed [W-1:0]  sra_res;
      assign amt     = operand_1[i*W +: SH];
      assign data    = operand_2[i*W +: W];
      assign sdata   = signed'(data);
      assign srl_res = data >> amt;
      assign sll_res = data << amt;
      // Kept in its own signed net so the arithmetic shift is not
      // demoted to a logical one by the unsigned select below.
      assign sra_res = sdata >>> amt;
      assign res_by_sew[s][i*W +: W] = (op == OP_SLL) ? sll_res :
                                       (op == OP_SRA) ? unsigned'(sra_res) : srl_res;
    end
  end

  assign result = res_by_sew[sew];

  // Only the low log2(SEW) bits of each amount element matter.
  logic unused_amt_bits;
  assign unused_amt_bits = ^operand_1;

endmodule

// File: rtl/vshift_seq.sv
// vshift_seq: vector shift sequencer. Accepts one command (op, sew, vl),
// streams ceil(vl / elements-per-chunk) operand chunks through vshift_unit
// into a single registered output stage, zeroes tail elements of the final
// chunk and pulses done (with err) when the last chunk leaves.
// Optional feature: define VSHIFT_SCALAR_EN to add cmd_scalar/cmd_scalar_amt,
// which replace every per-element shift amount with one latched scalar.
module vshift_seq
  import vshift_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int VL_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [2:0]            cmd_sew,
  input  logic [VL_W-1:0]       cmd_vl,
`ifdef VSHIFT_SCALAR_EN
  input  logic                  cmd_scalar,
  input  logic [5:0]            cmd_scalar_amt,
`endif
  input  logic                  opnd_valid,
  output logic                  opnd_ready,
  input  logic [DATA_WIDTH-1:0] opnd_a,
  input  logic [DATA_WIDTH-1:0] opnd_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(BYTES);

  state_e                state;
  logic [1:0]            op_q;
  logic [1:0]            sew_q;
  logic [VL_W-1:0]       vl_q;
  logic [VL_W-1:0]       nchunk_q;
  logic [VL_W-1:0]       chunk_idx;
  logic                  skip_q;
  logic                  err_q;
`ifdef VSHIFT_SCALAR_EN
  logic                  scalar_q;
  logic [5:0]            scalar_amt_q;
`endif

  logic                  cmd_fire;
  logic                  opnd_xfer;
  logic                  is_final;
  logic                  skip_in;
  int                    esh_cmd;
  int                    esh_run;
  int                    rem_run;
  logic [VL_W-1:0]       nchunk_calc;
  logic [DATA_WIDTH-1:0] amt_vec;
  logic [DATA_WIDTH-1:0] unit_res;
  logic [DATA_WIDTH-1:0] elem_mask;

  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;
  logic                  last_p1;

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign opnd_ready = (state == S_RUN) && (!vld_p1 || res_ready);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign opnd_xfer  = opnd_valid && opnd_ready;
  assign is_final   = (chunk_idx == nchunk_q - VL_W'(1));
  assign skip_in    = cmd_is_illegal(cmd_op, cmd_sew) || (cmd_vl == '0);

  // done is raised in the cycle the sequencer leaves DRAIN.
  assign done = (state == S_DRAIN) && (skip_q || (vld_p1 && res_ready && last_p1));
  assign err  = done && err_q;

  // Chunk count for the incoming command: elements per chunk is a power of two.
  always_comb begin
    esh_cmd     = LOG2B - int'(cmd_sew[1:0]);
    nchunk_calc = VL_W'((int'(cmd_vl) + (1 << esh_cmd) - 1) >> esh_cmd);
  end

  // Byte-enable mask: clear elements whose global index is at or past vl.
  always_comb begin
    esh_run   = LOG2B - int'(sew_q);
    rem_run   = int'(vl_q) - (int'(chunk_idx) << esh_run);
    elem_mask = '0;
    for (int j = 0; j < BYTES; j++) begin
      if ((j >> sew_q) < rem_run) elem_mask[j*8 +: 8] = 8'hFF;
    end
  end

`ifdef VSHIFT_SCALAR_EN
  // Scalar mode puts the latched amount in the low byte of every element.
  always_comb begin
    amt_vec = opnd_a;
    if (scalar_q) begin
      amt_vec = '0;
      for (int j = 0; j < BYTES; j++) begin
        if ((j & ((1 << sew_q) - 1)) == 0) amt_vec[j*8 +: 8] = {2'b00, scalar_amt_q};
      end
    end
  end
`else
  assign amt_vec = opnd_a;
`endif

  vshift_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_unit (
    .operand_1(amt_vec),
    .operand_2(opnd_b),
    .sew      (sew_q),
    .op       (op_q),
    .result   (unit_res)
  );

  // Sequencer FSM: command latch, chunk counting and state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op_q         <= '0;
      sew_q        <= '0;
      vl_q         <= '0;
      nchunk_q     <= '0;
      chunk_idx    <= '0;
      skip_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef VSHIFT_SCALAR_EN
      scalar_q     <= 1'b0;
      scalar_amt_q <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            op_q         <= cmd_op;
            sew_q        <= cmd_sew[1:0];
            vl_q         <= cmd_vl;
            nchunk_q     <= nchunk_calc;
            chunk_idx    <= '0;
            skip_q       <= skip_in;
            err_q        <= cmd_is_illegal(cmd_op, cmd_sew);
`ifdef VSHIFT_SCALAR_EN
            scalar_q     <= cmd_scalar;
            scalar_amt_q <= cmd_scalar_amt;
`endif
            state        <= skip_in ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (opnd_xfer) begin
            chunk_idx <= chunk_idx + VL_W'(1);
            if (is_final) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (done) begin
            state  <= S_IDLE;
            skip_q <= 1'b0;
            err_q  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- stage p1: registered result, held while the consumer stalls ----
  // Output register loads on operand transfer and empties on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (opnd_xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= unit_res & elem_mask;
      last_p1 <= is_final;
    end else if (res_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign res_valid = vld_p1;
  assign res_data  = data_p1;
  assign res_last  = last_p1;

endmodule
